// File: rtl/memory_access_pkg.sv
// memory_access_pkg: shared types and helpers for the memory-access stage
package memory_access_pkg;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
    } mem_op_e;

    typedef enum logic {IDLE, BUSY} mem_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [3:0]  cond;
        logic [3:0]  flags;
        logic        branch;
        logic        wback;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        mem_op_e     memop;
        logic [31:0] sdata;
    } signals_t;

    function automatic logic is_store(input mem_op_e op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic misaligned(input mem_op_e op, input logic [1:0] a);
        return ((op inside {MEM_LH, MEM_LHU, MEM_SH}) && a[0]) ||
               ((op inside {MEM_LW, MEM_SW}) && a != 2'b00);
    endfunction

    function automatic logic [3:0] store_strb(input mem_op_e op, input logic [1:0] a);
        return op == MEM_SB ? 4'b0001 << a :
               op == MEM_SH ? (a[1] ? 4'b1100 : 4'b0011) :
               op == MEM_SW ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic [31:0] store_data(input mem_op_e op, input logic [31:0] d);
        return op == MEM_SB ? {4{d[7:0]}} :
               op == MEM_SH ? {2{d[15:0]}} :
               op == MEM_SW ? d : 32'h0;
    endfunction

endpackage

// File: rtl/memory_access_load_extend.sv
// load_extend: picks the addressed byte/half from a load word and extends it
module load_extend
    import memory_access_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_op_e     op,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    // lane select then sign/zero extension by access kind
    always_comb begin
        b = rdata[{offset, 3'b000} +: 8];
        h = rdata[{offset[1], 4'b0000} +: 16];
        result = op == MEM_LB  ? {{24{b[7]}}, b} :
                 op == MEM_LBU ? {24'h0, b} :
                 op == MEM_LH  ? {{16{h[15]}}, h} :
                 op == MEM_LHU ? {16'h0, h} : rdata;
    end

endmodule

// File: rtl/memory_access.sv
// memory_access: pipeline stage issuing loads/stores on a valid/ready data bus
module memory_access
    import memory_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  signals_t        i_signals,
    output logic            i_stall,
    output signals_t        o_signals,
    output logic            o_misalign,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_wstrb,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata
);

    mem_state_e      state_q, state_d;
    signals_t        cap_q, cap_d, o_q, o_d;
    logic            mis_q, mis_d, req_q, req_d, we_q, we_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]      strb_q, strb_d;
    logic [31:0]     ld_res;
    logic            is_mem, start, bad, done;

    load_extend u_load_extend (
        .rdata  (mem_rdata),
        .offset (cap_q.wdata[1:0]),
        .op     (cap_q.memop),
        .result (ld_res)
    );

    assign is_mem     = i_signals.valid && i_signals.memop != MEM_NONE;
    assign start      = state_q == IDLE && is_mem && !misaligned(i_signals.memop, i_signals.wdata[1:0]);
    assign bad        = state_q == IDLE && is_mem && misaligned(i_signals.memop, i_signals.wdata[1:0]);
    assign done       = state_q == BUSY && mem_ready;
    assign i_stall    = state_q == BUSY;
    assign o_signals  = o_q;
    assign o_misalign = mis_q;
    assign mem_req    = req_q;
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wstrb  = strb_q;

    // state and datapath registers; reset also abandons an open transaction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cap_q   <= '0;
            o_q     <= '0;
            mis_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            cap_q   <= cap_d;
            o_q     <= o_d;
            mis_q   <= mis_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
        end
    end

    // enter BUSY on an aligned memory op, leave when the bus completes
    always_comb begin
        state_d = start ? BUSY : done ? IDLE : state_q;
    end

    // bus fields latch at issue and hold; result is built from the captured op
    always_comb begin
        signals_t idle_o, busy_o, fin_o;
        cap_d   = start ? i_signals : cap_q;
        req_d   = start || (req_q && !mem_ready);
        we_d    = start ? is_store(i_signals.memop) : we_q;
        addr_d  = start ? {i_signals.wdata[31:2], 2'b00} : addr_q;
        wdata_d = start ? store_data(i_signals.memop, i_signals.sdata) : wdata_q;
        strb_d  = start ? store_strb(i_signals.memop, i_signals.wdata[1:0]) : strb_q;
        mis_d   = bad;
        idle_o       = i_signals;
        idle_o.valid = i_signals.valid && i_signals.memop == MEM_NONE;
        busy_o       = o_q;
        busy_o.valid = 1'b0;
        fin_o        = cap_q;
        fin_o.valid  = 1'b1;
        fin_o.wdata  = is_store(cap_q.memop) ? 32'h0 : ld_res;
        fin_o.wback  = cap_q.wback && !is_store(cap_q.memop);
        o_d = state_q == BUSY ? (done ? fin_o : busy_o) : idle_o;
    end

endmodule
